rob_resp_arb: RTL and testbench
===============================

Name: rob_resp_arb

Overview:
- Response-side arbiter that shares the single upstream read-data channel (u_ch_*) between the ROB banks.
- Each bank presents a valid/ready/128-bit beat. The block picks one bank per beat in round-robin order and forwards the beat upstream tagged with its bank id.
- Holds the grant until the upstream handshake completes, so the upstream channel is valid-stable.
- Sits between the per-bank ROB instances and the upstream channel consumer, replacing a plain OR-of-valids mux.

Parameters:
- BankNum, 4, number of ROB banks arbitrated (power of two, 2..8).
- DataWidth, 128, beat width in bits.
- BankIdWidth, $clog2(BankNum), width of the bank id.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- d_bank_valid  input  BankNum  per-bank beat valid.
- d_bank_ready  output  BankNum  per-bank beat accept.
- d_bank_data  input  BankNum*DataWidth  per-bank beat; bank i occupies bits [i*DataWidth +: DataWidth].
- u_ch_valid  output  1  upstream beat valid.
- u_ch_ready  input  1  upstream accept.
- u_ch_data  output  DataWidth  upstream beat.
- u_ch_bank_id  output  BankIdWidth  source bank of the current beat.
- arb_busy  output  1  a grant is locked or the output register is full.

Behaviour:
- **Bank rules.** A bank must hold valid and data stable until its d_bank_ready is high in the same cycle. Banks may raise valid at any time.
- **Round-robin pointer.** rr_ptr (BankIdWidth bits) marks the highest-priority bank.
  - Reset value is 0.
  - On a bank handshake from bank g: rr_ptr <= (g+1) mod BankNum, wrapping from BankNum-1 to 0.
  - No handshake: rr_ptr holds.
- **Grant selection.** Grant is the first valid bank scanning rr_ptr, rr_ptr+1, ... modulo BankNum. No valid bank means no grant.
- **Lock state machine** (without MPC_ROB_ARB_OUTREG_EN). States are IDLE and LOCKED.
  - IDLE: grant is combinational from the pointer.
  - IDLE -> LOCKED: u_ch_valid=1 and u_ch_ready=0; the granted id is saved in lock_id.
  - LOCKED: grant is forced to lock_id, even if a higher-priority bank raises valid.
  - LOCKED -> IDLE: on u_ch_ready=1.
- **Handshake and outputs.**
  - d_bank_ready[g] = u_ch_ready when g is granted; all other ready bits are 0.
  - u_ch_data and u_ch_bank_id come from the granted bank.
  - Latency is 0 cycles. Throughput is 1 beat per cycle.
- **Simultaneous requests.** All banks valid with u_ch_ready held high gives grants in strict rotation, e.g. 0,1,2,3,0.
- **Idle outputs.** With no grant: u_ch_valid=0, u_ch_data=0, u_ch_bank_id=0.
- **Reset values.** d_bank_ready=0, u_ch_valid=0, u_ch_data=0, u_ch_bank_id=0, arb_busy=0, rr_ptr=0, state IDLE.
- **Reset mid-operation.** Any locked grant or held beat is discarded with no upstream handshake. Banks re-present their beats after reset.
- **arb_busy.** Equals state==LOCKED, or the output register is full when the register is compiled in.

Optional Feature:
- Macro: MPC_ROB_ARB_OUTREG_EN.
- **Defined:** a 1-entry full-throughput output register drives u_ch_*, for timing isolation.
  - Load enable = !full | u_ch_ready.
  - d_bank_ready[g] = load enable for the granted bank.
  - A load captures data and bank id and advances rr_ptr.
  - Latency is 1 cycle; sustained throughput stays 1 beat per cycle.
  - The lock FSM is not instantiated: the register provides valid stability.
  - Full register, u_ch_ready=0: no d_bank_ready asserted.
  - Full register, u_ch_ready=1: drain and load in the same cycle.
- **Undefined:** the combinational path and lock FSM described in Behaviour.

Decomposition:
- **Package mpc_types:**
  - ROB_BANK_NUM constant.
  - robBankId_t typedef.
  - rob_beat_t struct {data, bank_id}.
- **Sub-module rr_arb:** a generic BankNum-way round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, grant id, any-valid.
  - Purely combinational. The pointer and lock registers stay in rob_resp_arb.

Test Plan:
- **Rotation:** all four banks valid, u_ch_ready=1 for 8 cycles -> bank ids 0,1,2,3,0,1,2,3; each bank's data appears exactly on its turn.
- **Lock:** only bank 2 valid, u_ch_ready=0 for 3 cycles; bank 0 raises valid at cycle 1 -> grant stays on bank 2, u_ch_data stable, d_bank_ready=0. Ready at cycle 3 -> bank 2 handshakes, then bank 0 is next.
- **Pointer wrap:** bank 3 handshakes, then banks 0 and 3 are both valid -> bank 0 wins.
- **Idle:** no bank valid -> u_ch_valid=0, u_ch_data=0, arb_busy=0, rr_ptr unchanged.
- **Reset mid-operation:** rst asserted while LOCKED on bank 1 -> next cycle all outputs 0, rr_ptr=0, no handshake on bank 1.
- **MPC_ROB_ARB_OUTREG_EN:** all banks valid, u_ch_ready toggles 1,0,1 -> first beat appears 1 cycle after its load, register holds while ready=0, no beat lost or duplicated.

Source files
------------

// File: rtl/rob_resp_arb_pkg.sv
// Shared types for the ROB response arbiter: bank count, bank id, beat record
// and the lock FSM state encoding.
package mpc_types;

  localparam int ROB_BANK_NUM = 4;
  localparam int ROB_DATA_W   = 128;

  typedef logic [$clog2(ROB_BANK_NUM)-1:0] robBankId_t;

  typedef struct packed {
    logic [ROB_DATA_W-1:0] data;
    robBankId_t            bank_id;
  } rob_beat_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rob_resp_arb_rr_arb.sv
// Combinational N-way round-robin picker: first requester at or after ptr wins.
// N must be a power of two so the index wraps by truncation.
module rr_arb #(
  parameter int N       = 4,
  parameter int IdWidth = $clog2(N)
) (
  input  logic [N-1:0]       req,
  input  logic [IdWidth-1:0] ptr,
  output logic [N-1:0]       gnt,
  output logic [IdWidth-1:0] gnt_id,
  output logic               any_vld
);

  logic [IdWidth-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    any_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + IdWidth'(i);
      if (!any_vld && req[idx]) begin
        any_vld  = 1'b1;
        gnt_id   = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_resp_arb.sv
// Round-robin arbiter sharing the upstream read-data channel between ROB banks.
// Build option MPC_ROB_ARB_OUTREG_EN replaces the lock FSM with a 1-entry output register.
//
//   state      | meaning
//   ARB_IDLE   | grant follows the round-robin pick each cycle
//   ARB_LOCKED | upstream stalled a valid beat; grant pinned to lock_id
module rob_resp_arb
  import mpc_types::*;
#(
  parameter int BankNum     = ROB_BANK_NUM,
  parameter int DataWidth   = ROB_DATA_W,
  parameter int BankIdWidth = $clog2(BankNum)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BankNum-1:0]           d_bank_valid,
  output logic [BankNum-1:0]           d_bank_ready,
  input  logic [BankNum*DataWidth-1:0] d_bank_data,
  output logic                         u_ch_valid,
  input  logic                         u_ch_ready,
  output logic [DataWidth-1:0]         u_ch_data,
  output logic [BankIdWidth-1:0]       u_ch_bank_id,
  output logic                         arb_busy
);

  logic [BankIdWidth-1:0] rr_ptr;
  logic [BankNum-1:0]     pick_oh;
  logic [BankIdWidth-1:0] pick_id;
  logic                   pick_vld;

  rr_arb #(
    .N       (BankNum),
    .IdWidth (BankIdWidth)
  ) u_rr_arb (
    .req     (d_bank_valid),
    .ptr     (rr_ptr),
    .gnt     (pick_oh),
    .gnt_id  (pick_id),
    .any_vld (pick_vld)
  );

`ifdef MPC_ROB_ARB_OUTREG_EN

  logic                   full;
  logic [DataWidth-1:0]   data_q;
  logic [BankIdWidth-1:0] id_q;
  logic [DataWidth-1:0]   pick_data;
  logic                   load_en;
  logic                   load;

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < BankNum; i++) begin
      if (pick_oh[i]) pick_data = pick_data | d_bank_data[i*DataWidth +: DataWidth];
    end
  end

  // Drain and refill in the same cycle keeps one beat per cycle sustained.
  assign load_en = !full || u_ch_ready;
  assign load    = pick_vld && load_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= 1'b0;
      data_q <= '0;
      id_q   <= '0;
      rr_ptr <= '0;
    end else if (load) begin
      full   <= 1'b1;
      data_q <= pick_data;
      id_q   <= pick_id;
      rr_ptr <= pick_id + BankIdWidth'(1);
    end else if (u_ch_ready) begin
      full   <= 1'b0;
    end
  end

  assign d_bank_ready = load_en ? pick_oh : '0;
  assign u_ch_valid   = full;
  assign u_ch_data    = full ? data_q : '0;
  assign u_ch_bank_id = full ? id_q : '0;
  assign arb_busy     = full;

`else

  arb_state_e             state, state_nxt;
  logic [BankIdWidth-1:0] lock_id, lock_id_nxt;
  logic [BankNum-1:0]     sel_oh;
  logic [BankIdWidth-1:0] sel_id;
  logic                   sel_vld;
  logic [DataWidth-1:0]   sel_data;

  // A locked bank is guaranteed valid by the bank hold rule, so no req check.
  always_comb begin
    sel_oh  = pick_oh;
    sel_id  = pick_id;
    sel_vld = pick_vld;
    if (state == ARB_LOCKED) begin
      sel_id  = lock_id;
      sel_vld = 1'b1;
      for (int i = 0; i < BankNum; i++) begin
        sel_oh[i] = (lock_id == BankIdWidth'(i));
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < BankNum; i++) begin
      if (sel_oh[i]) sel_data = sel_data | d_bank_data[i*DataWidth +: DataWidth];
    end
  end

  always_comb begin
    state_nxt   = state;
    lock_id_nxt = lock_id;
    case (state)
      ARB_IDLE: begin
        if (sel_vld && !u_ch_ready) begin
          state_nxt   = ARB_LOCKED;
          lock_id_nxt = sel_id;
        end
      end
      ARB_LOCKED: begin
        if (u_ch_ready) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      lock_id <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      lock_id <= lock_id_nxt;
      if (sel_vld && u_ch_ready) rr_ptr <= sel_id + BankIdWidth'(1);
    end
  end

  assign d_bank_ready = u_ch_ready ? sel_oh : '0;
  assign u_ch_valid   = sel_vld;
  assign u_ch_data    = sel_data;
  assign u_ch_bank_id = sel_vld ? sel_id : '0;
  assign arb_busy     = (state == ARB_LOCKED);

`endif

endmodule

// File: tb/tb_rob_resp_arb.sv
// Directed bench for rob_resp_arb: reset, rotation, wrap, idle, lock and mid-lock reset;
// output-register build checked when MPC_ROB_ARB_OUTREG_EN is defined.
module tb_rob_resp_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   d_bank_valid;
  logic [3:0]   d_bank_ready;
  logic [511:0] d_bank_data;
  logic         u_ch_valid;
  logic         u_ch_ready;
  logic [127:0] u_ch_data;
  logic [1:0]   u_ch_bank_id;
  logic         arb_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rob_resp_arb dut (
    .clk          (clk),
    .rst          (rst),
    .d_bank_valid (d_bank_valid),
    .d_bank_ready (d_bank_ready),
    .d_bank_data  (d_bank_data),
    .u_ch_valid   (u_ch_valid),
    .u_ch_ready   (u_ch_ready),
    .u_ch_data    (u_ch_data),
    .u_ch_bank_id (u_ch_bank_id),
    .arb_busy     (arb_busy)
  );

  function automatic logic [127:0] dat(input int b);
    logic [31:0] w;
    w = 32'hA5A5_0000 + 32'(b) * 32'h0101;
    return {w, ~w, w ^ 32'h1234_5678, w + 32'd7};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    d_bank_valid = 4'b0000;
    u_ch_ready   = 1'b0;
    for (int i = 0; i < 4; i++) d_bank_data[i*128 +: 128] = dat(i);
    tick();
    tick();
    chk("rst_valid", 128'(u_ch_valid), 128'd0);
    chk("rst_ready", 128'(d_bank_ready), 128'd0);
    chk("rst_data", u_ch_data, 128'd0);
    chk("rst_id", 128'(u_ch_bank_id), 128'd0);
    chk("rst_busy", 128'(arb_busy), 128'd0);
    chk("rst_ptr", 128'(dut.rr_ptr), 128'd0);
    rst = 1'b0;

`ifdef MPC_ROB_ARB_OUTREG_EN
    d_bank_valid = 4'b1111;
    u_ch_ready   = 1'b1;
    #1;
    chk("or_empty_valid", 128'(u_ch_valid), 128'd0);
    chk("or_empty_ready", 128'(d_bank_ready), 128'b0001);
    tick();
    chk("or_b0_valid", 128'(u_ch_valid), 128'd1);
    chk("or_b0_id", 128'(u_ch_bank_id), 128'd0);
    chk("or_b0_data", u_ch_data, dat(0));
    chk("or_b0_rdy", 128'(d_bank_ready), 128'b0010);
    u_ch_ready = 1'b0;
    #1;
    chk("or_stall_rdy", 128'(d_bank_ready), 128'd0);
    tick();
    chk("or_hold_id", 128'(u_ch_bank_id), 128'd0);
    chk("or_hold_data", u_ch_data, dat(0));
    chk("or_hold_busy", 128'(arb_busy), 128'd1);
    u_ch_ready = 1'b1;
    #1;
    chk("or_drain_rdy", 128'(d_bank_ready), 128'b0010);
    tick();
    chk("or_b1_id", 128'(u_ch_bank_id), 128'd1);
    chk("or_b1_data", u_ch_data, dat(1));
    tick();
    chk("or_b2_id", 128'(u_ch_bank_id), 128'd2);
`else
    // rotation
    d_bank_valid = 4'b1111;
    u_ch_ready   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rot_id", 128'(u_ch_bank_id), 128'(k % 4));
      chk("rot_data", u_ch_data, dat(k % 4));
      chk("rot_ready", 128'(d_bank_ready), 128'(4'b0001 << (k % 4)));
      tick();
    end
    chk("rot_ptr", 128'(dut.rr_ptr), 128'd0);

    // idle
    d_bank_valid = 4'b0000;
    #1;
    chk("idle_valid", 128'(u_ch_valid), 128'd0);
    chk("idle_data", u_ch_data, 128'd0);
    chk("idle_ready", 128'(d_bank_ready), 128'd0);
    chk("idle_busy", 128'(arb_busy), 128'd0);
    tick();
    chk("idle_ptr", 128'(dut.rr_ptr), 128'd0);

    // pointer wrap
    d_bank_valid = 4'b0100;
    tick();
    chk("wrap_ptr3", 128'(dut.rr_ptr), 128'd3);
    d_bank_valid = 4'b1000;
    #1;
    chk("wrap_id3", 128'(u_ch_bank_id), 128'd3);
    tick();
    chk("wrap_ptr0", 128'(dut.rr_ptr), 128'd0);
    d_bank_valid = 4'b1001;
    #1;
    chk("wrap_win0", 128'(u_ch_bank_id), 128'd0);
    chk("wrap_rdy0", 128'(d_bank_ready), 128'b0001);
    tick();
    d_bank_valid = 4'b1000;
    tick();
    chk("lock_ptr0", 128'(dut.rr_ptr), 128'd0);

    // lock on bank 2 while bank 0 (higher priority) arrives
    d_bank_valid = 4'b0100;
    u_ch_ready   = 1'b0;
    #1;
    chk("lock_c0_valid", 128'(u_ch_valid), 128'd1);
    chk("lock_c0_id", 128'(u_ch_bank_id), 128'd2);
    chk("lock_c0_rdy", 128'(d_bank_ready), 128'd0);
    tick();
    d_bank_valid = 4'b0101;
    #1;
    chk("lock_c1_id", 128'(u_ch_bank_id), 128'd2);
    chk("lock_c1_data", u_ch_data, dat(2));
    chk("lock_c1_rdy", 128'(d_bank_ready), 128'd0);
    chk("lock_c1_busy", 128'(arb_busy), 128'd1);
    tick();
    chk("lock_c2_id", 128'(u_ch_bank_id), 128'd2);
    chk("lock_c2_data", u_ch_data, dat(2));
    u_ch_ready = 1'b1;
    #1;
    chk("lock_c3_rdy", 128'(d_bank_ready), 128'b0100);
    tick();
    chk("lock_ptr3", 128'(dut.rr_ptr), 128'd3);
    d_bank_valid = 4'b0001;
    #1;
    chk("lock_next_id", 128'(u_ch_bank_id), 128'd0);
    chk("lock_next_busy", 128'(arb_busy), 128'd0);
    tick();
    chk("lock_next_ptr", 128'(dut.rr_ptr), 128'd1);

    // reset while locked on bank 1
    d_bank_valid = 4'b0010;
    u_ch_ready   = 1'b0;
    #1;
    chk("rmid_id", 128'(u_ch_bank_id), 128'd1);
    tick();
    chk("rmid_busy", 128'(arb_busy), 128'd1);
    rst          = 1'b1;
    d_bank_valid = 4'b0000;
    #1;
    chk("rmid_rdy", 128'(d_bank_ready), 128'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rmid_valid", 128'(u_ch_valid), 128'd0);
    chk("rmid_data", u_ch_data, 128'd0);
    chk("rmid_busy0", 128'(arb_busy), 128'd0);
    chk("rmid_ptr", 128'(dut.rr_ptr), 128'd0);
    d_bank_valid = 4'b0010;
    u_ch_ready   = 1'b1;
    #1;
    chk("rmid_re_id", 128'(u_ch_bank_id), 128'd1);
    chk("rmid_re_rdy", 128'(d_bank_ready), 128'b0010);
    tick();
    chk("rmid_re_ptr", 128'(dut.rr_ptr), 128'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
